// File: rtl/image_link_arbiter_if.sv
// rtl/image_link_arbiter_if.sv - signal bundle between frame sources, link arbiter and image sender
// Purpose: groups every non-clock/reset signal of image_link_arbiter into one port.
// Signals:
//   req          NUM_REQ         per-source frame request (level)
//   pix_in       NUM_REQ*DATA_W  packed pixel buses, source i at [i*DATA_W +: DATA_W]
//   image_ready  1               sender reports frame received
//   grant        NUM_REQ         one-hot current owner, 0 when free
//   done         NUM_REQ         one-cycle completion pulse to the owner
//   reset_signal 1               reset to the image sender, 1 = held in reset
//   data_out     DATA_W          selected pixel, 0 outside SEND
//   busy         1               1 whenever the arbiter is not idle
//   timeout_err  1               one-cycle pulse on SEND timeout
// Modports: slave = arbiter side, master = sources/sender side.
interface image_link_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 12
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] pix_in;
   logic                      image_ready;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      reset_signal;
   logic [DATA_W-1:0]         data_out;
   logic                      busy;
   logic                      timeout_err;

   modport slave (
      input  req, pix_in, image_ready,
      output grant, done, reset_signal, data_out, busy, timeout_err
   );

   modport master (
      output req, pix_in, image_ready,
      input  grant, done, reset_signal, data_out, busy, timeout_err
   );
endinterface

// File: rtl/image_link_arbiter.sv
// rtl/image_link_arbiter.sv - round-robin arbiter sharing one image link between frame sources
// Purpose: grants the image link to one source per whole frame, round-robin, and sequences
//   the sender per grant: reset pulse (RESET_TIME) -> stream until image_ready -> gap (GAP_TIME).
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   link   image_link_arbiter_if.slave (req, pix_in, image_ready in;
//          grant, done, reset_signal, data_out, busy, timeout_err out)
// Optional feature: define IMAGE_LINK_TIMEOUT_EN to abort SEND after TIMEOUT cycles
//   without image_ready (timeout_err pulse, no done). Undefined: SEND waits forever.
module image_link_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_W     = 12,
   parameter int RESET_TIME = 50_000_000,
   parameter int GAP_TIME   = 50_000_000,
   parameter int TIMEOUT    = 500_000_000
) (
   input logic                 clk,
   input logic                 reset,
   image_link_arbiter_if.slave link
);
   localparam int          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [31:0] HOLD_LAST = 32'(RESET_TIME - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_TIME - 1);
`ifdef IMAGE_LINK_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RESET_HOLD, S_SEND, S_GAP} state_t;

   state_t             state, state_next;
   logic [PTR_W-1:0]   ptr, ptr_next;
   logic [31:0]        cnt, cnt_next;
   logic [NUM_REQ-1:0] grant_q, grant_next;
   logic [NUM_REQ-1:0] done_q, done_next;
   logic               terr_q, terr_next;
   logic               winner_found;
   logic [PTR_W-1:0]   winner;
   logic               cnt_en;

   // Search starts one past the last owner so every waiting source is served before a repeat.
   always_comb begin : rr_search
      int idx;
      idx          = 0;
      winner_found = 1'b0;
      winner       = ptr;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!winner_found && link.req[idx]) begin
            winner_found = 1'b1;
            winner       = idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      grant_next = grant_q;
      done_next  = '0;
      terr_next  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (winner_found) begin
               grant_next = NUM_REQ'(1) << winner;
               ptr_next   = winner;
               state_next = S_RESET_HOLD;
            end
         end
         S_RESET_HOLD: begin
            if (cnt == HOLD_LAST) state_next = S_SEND;
         end
         S_SEND: begin
            // image_ready is checked first so it wins over a simultaneous timeout.
            if (link.image_ready) begin
               done_next  = grant_q;
               grant_next = '0;
               state_next = S_GAP;
            end
`ifdef IMAGE_LINK_TIMEOUT_EN
            else if (cnt >= TIMEOUT_LAST) begin
               terr_next  = 1'b1;
               grant_next = '0;
               state_next = S_GAP;
            end
`endif
         end
         S_GAP: begin
            if (cnt == GAP_LAST) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

`ifdef IMAGE_LINK_TIMEOUT_EN
   assign cnt_en = (state != S_IDLE);
`else
   assign cnt_en = (state == S_RESET_HOLD) || (state == S_GAP);
`endif

   // One shared counter: cleared on every state change, saturating otherwise.
   always_comb begin
      cnt_next = cnt;
      if (state_next != state)      cnt_next = '0;
      else if (cnt_en && cnt != '1) cnt_next = cnt + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         ptr     <= PTR_W'(NUM_REQ - 1);
         cnt     <= '0;
         grant_q <= '0;
         done_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         cnt     <= cnt_next;
         grant_q <= grant_next;
         done_q  <= done_next;
         terr_q  <= terr_next;
      end
   end

   assign link.grant        = grant_q;
   assign link.done         = done_q;
   assign link.timeout_err  = terr_q;
   assign link.busy         = (state != S_IDLE);
   assign link.reset_signal = (state != S_SEND);
   // ptr holds the current owner for the whole frame, so it selects the pixel bus.
   assign link.data_out     = (state == S_SEND) ? link.pix_in[int'(ptr)*DATA_W +: DATA_W] : '0;
endmodule
